otter_alu_arbiter: RTL
======================

Name: otter_alu_arbiter

Overview:
- Shares one combinational otter_alu instance between two requesters: port 0 is the execute stage, port 1 is the address/CSR helper.
- Each port has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, or optionally fixed priority.
- The result is registered and held until the owning requester accepts it.

Parameters:
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority with port 0 always winning.
- CNT_W, 32, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a  in  32  port 0 operand A.
- req0_b  in  32  port 0 operand B.
- req0_func  in  4  port 0 ALU function code (ALU_* encoding).
- req1_valid / req1_ready / req1_a / req1_b / req1_func: port 1 equivalents, same directions and widths.
- rsp0_valid  out  1  port 0 result valid.
- rsp0_ready  in  1  port 0 result consumed.
- rsp1_valid  out  1  port 1 result valid.
- rsp1_ready  in  1  port 1 result consumed.
- rsp_result  out  32  registered ALU result, shared by both response ports.
- busy  out  1  high while a response is pending.
- op_count  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, owner=0, rr_ptr=0 (port 0 preferred).
  - rsp0_valid=0, rsp1_valid=0, rsp_result=0, busy=0, op_count=0.
  - req*_ready are combinational and therefore 0 while rst is high.
- States: IDLE (no pending result) and RESP (result held for `owner`).
- Accept window: `accept_ok = (state==IDLE) | (state==RESP & rsp_fire)`, where `rsp_fire = rsp<owner>_valid & rsp<owner>_ready`.
- Grant, evaluated only when accept_ok is high:
  - Exactly one reqN_valid → that port is granted.
  - Both valid, RR_EN=1 → grant port rr_ptr.
  - Both valid, RR_EN=0 → grant port 0.
  - reqN_ready = accept_ok & grant==N. At most one ready is high per cycle.
- Accept edge (reqN_valid & reqN_ready):
  - rsp_result <= alu(reqN_a, reqN_b, reqN_func), computed from the live request inputs through the single internal ALU.
  - owner <= N; state <= RESP.
  - With RR_EN=1, rr_ptr <= ~N.
- Latency: the response is valid on the cycle after acceptance. rspN_valid = (state==RESP) & owner==N.
- Response held: while in RESP with no handshake, rsp_result, owner and rspN_valid stay stable.
- Response handshake:
  - op_count increments.
  - If a new request is accepted on the same edge, remain in RESP with the new owner and result. Back-to-back throughput is one op per cycle.
  - Otherwise go to IDLE.
- rsp_ready on the non-owner port is ignored.
- Requester contract: once valid is raised, payload stays stable and valid stays high until ready. The arbiter does not check this.
- Invalid func codes pass through to the ALU; rsp_result is whatever otter_alu produces (32'hDEADDEAD for 4'b1111).
- Shift amounts use src_b[4:0], as the ALU defines.
- busy = (state==RESP).
- Reset mid-operation: the pending response is discarded with no handshake and no op_count increment. rr_ptr returns to 0.
- Combinational paths: req*_ready depends on rsp<owner>_ready. No path exists from req*_valid to rsp*.

Decomposition:
- Shared package / otter_defines.vh holds:
  - ALU_* function codes and their 4-bit width.
  - The arbiter state encoding (ARB_IDLE, ARB_RESP).
  - The ALU_DEFAULT_RESULT constant 32'hDEADDEAD, for benches.
- One sub-module: otter_alu, instantiated once, with its operand and func inputs driven by the grant mux.
- Grant logic stays inline (two ports only).

Test Plan:
1. Single request: req0 {A=12345678, B=87654321, func=ALU_ADD} with rsp0_ready=1 → req0_ready=1 in the same cycle. Next cycle rsp0_valid=1 and rsp_result=99999999; op_count becomes 1 on the following edge.
2. Contention, RR_EN=1: both ports held valid (port 0 ALU_SUB 87654321-12345678; port 1 ALU_SLTU 7FFFFFFF,80000000), both rsp ready → grant order 0,1,0,1. Results alternate 7530ECA9 and 00000001; one result per cycle after the first.
3. Backpressure: port 1 ALU_SRA 80000000>>1F accepted, rsp1_ready=0 for 5 cycles → rsp_result=FFFFFFFF held stable, req0_ready=0 throughout. After rsp1_ready=1, port 0 is accepted on the same edge.
4. Fixed priority, RR_EN=0: both ports valid continuously → port 0 granted every time and port 1 starves. Deasserting req0_valid lets port 1 be granted on the next accept window.
5. Invalid func 4'b1111 on port 0 → rsp_result=DEADDEAD, rsp0_valid=1, no lockup.
6. rst pulsed asynchronously mid-RESP with a pending result → rsp*_valid, busy and rsp_result drop to 0 immediately. op_count stays unchanged (0 if nothing has completed yet). After release, port 0 wins the first contested grant.

Source files
------------

// File: rtl/otter_alu_arbiter_pkg.sv
// Shared definitions for the OTTER ALU arbiter: ALU function codes, arbiter
// state encoding and the result the ALU produces for unknown function codes.
package otter_alu_arbiter_pkg;

    localparam int ALU_FUNC_W = 4;
    localparam int XLEN       = 32;

    localparam logic [ALU_FUNC_W-1:0] ALU_ADD      = 4'b0000;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLL      = 4'b0001;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLT      = 4'b0010;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLTU     = 4'b0011;
    localparam logic [ALU_FUNC_W-1:0] ALU_XOR      = 4'b0100;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRL      = 4'b0101;
    localparam logic [ALU_FUNC_W-1:0] ALU_OR       = 4'b0110;
    localparam logic [ALU_FUNC_W-1:0] ALU_AND      = 4'b0111;
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB      = 4'b1000;
    localparam logic [ALU_FUNC_W-1:0] ALU_LUI_COPY = 4'b1001;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRA      = 4'b1101;

    localparam logic [XLEN-1:0] ALU_DEFAULT_RESULT = 32'hDEADDEAD;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/otter_alu_arbiter_alu.sv
// Combinational OTTER ALU; unknown function codes yield ALU_DEFAULT_RESULT.
module otter_alu
    import otter_alu_arbiter_pkg::*;
(
    input  logic [XLEN-1:0]       src_a,
    input  logic [XLEN-1:0]       src_b,
    input  logic [ALU_FUNC_W-1:0] func,
    output logic [XLEN-1:0]       result
);

    logic [4:0] shamt;

    assign shamt = src_b[4:0];

    always_comb begin
        result = ALU_DEFAULT_RESULT;
        case (func)
            ALU_ADD:      result = src_a + src_b;
            ALU_SUB:      result = src_a - src_b;
            ALU_OR:       result = src_a | src_b;
            ALU_AND:      result = src_a & src_b;
            ALU_XOR:      result = src_a ^ src_b;
            ALU_SRL:      result = src_a >> shamt;
            ALU_SLL:      result = src_a << shamt;
            ALU_SRA:      result = $signed(src_a) >>> shamt;
            ALU_SLT:      result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:     result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_LUI_COPY: result = src_a;
            default:      result = ALU_DEFAULT_RESULT;
        endcase
    end

endmodule

// File: rtl/otter_alu_arbiter.sv
// Two-port arbiter sharing one otter_alu; the registered result is held until
// the owning port completes its response handshake.
module otter_alu_arbiter
    import otter_alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [XLEN-1:0]       req0_a,
    input  logic [XLEN-1:0]       req0_b,
    input  logic [ALU_FUNC_W-1:0] req0_func,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [XLEN-1:0]       req1_a,
    input  logic [XLEN-1:0]       req1_b,
    input  logic [ALU_FUNC_W-1:0] req1_func,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [XLEN-1:0]       rsp_result,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    arb_state_t            state;
    arb_state_t            next_state;
    logic                  owner;
    logic                  rr_ptr;
    logic                  grant;
    logic                  rsp_fire;
    logic                  accept_ok;
    logic                  accept;
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;
    logic [ALU_FUNC_W-1:0] alu_func;
    logic [XLEN-1:0]       alu_result;

    assign busy       = (state == ARB_RESP);
    assign rsp0_valid = (state == ARB_RESP) && !owner;
    assign rsp1_valid = (state == ARB_RESP) && owner;
    assign rsp_fire   = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

    // A new request may enter when idle or on the same edge the held result drains.
    assign accept_ok = !rst && ((state == ARB_IDLE) || rsp_fire);

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? rr_ptr : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = accept_ok && !grant;
    assign req1_ready = accept_ok && grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign alu_a    = grant ? req1_a    : req0_a;
    assign alu_b    = grant ? req1_b    : req0_b;
    assign alu_func = grant ? req1_func : req0_func;

    otter_alu u_alu (
        .src_a  (alu_a),
        .src_b  (alu_b),
        .func   (alu_func),
        .result (alu_result)
    );

    always_comb begin
        next_state = state;
        if (accept) begin
            next_state = ARB_RESP;
        end else if (rsp_fire) begin
            next_state = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            rsp_result <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                owner      <= grant;
                rsp_result <= alu_result;
                if (RR_EN) begin
                    rr_ptr <= ~grant;
                end
            end
            if (rsp_fire) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
